tx_scrambler_64b66b: RTL and testbench
======================================

Name: tx_scrambler_64b66b

Overview:
TX-path self-synchronizing scrambler for 10GBASE-R, polynomial G(x) = 1 + x^39 + x^58. It sits between the 64b/66b encoder and the TX gearbox.
- Takes 32-bit encoded half-blocks plus a 2-bit sync header.
- Scrambles the payload only; the header bypasses the scrambler.
- Presents registered data/header/valid to the gearbox and relays the gearbox back-pressure upstream.

Parameters:
DATA_WIDTH, 32, payload word width; only 32 is supported.
LFSR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded at reset.
BYPASS, 0, 1 = payload passes unscrambled (bring-up/debug); all timing is unchanged.

Ports:
i_clk  input  1  core clock (PCS TX clock)
i_reset  input  1  synchronous, active-high reset
i_data  input  32  encoded payload half-block; bit 0 is transmitted first
i_data_valid  input  1  i_data/i_hdr valid this cycle
i_hdr  input  2  sync header; meaningful only on the first half of each 66-bit block
i_gearbox_pause  input  1  back-pressure from gearbox
o_data  output  32  scrambled payload to gearbox
o_data_valid  output  1  o_data valid
o_hdr  output  2  header aligned to first-half word
o_encoder_pause  output  1  back-pressure to encoder
o_hdr_err  output  1  one-cycle pulse: invalid header (00/11) accepted on a first-half word

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - o_data=0, o_data_valid=0, o_hdr=2'b00, o_hdr_err=0.
  - LFSR state=LFSR_SEED, half-select toggle=0 (expect first half).
  - Reset mid-block discards the partial block; the next accepted word is treated as a first half.
- o_encoder_pause = i_gearbox_pause, purely combinational, no latency.
- Accept condition: i_data_valid=1 and i_gearbox_pause=0.
- Latency: 1 cycle. An accepted word appears on o_data/o_hdr the following cycle with o_data_valid=1.
- Pause cycle (i_gearbox_pause=1):
  - Input is ignored; no LFSR advance, no toggle change.
  - o_data, o_hdr and o_data_valid hold their previous values, so the gearbox counter is not disturbed.
- Idle cycle (i_data_valid=0, no pause): o_data_valid<=0; o_data/o_hdr hold; LFSR and toggle hold.
- Scrambling, per accepted word, for bit i in 0..31 with S = the 58 most recent scrambled output bits:
  - out[i] = d[i] ^ S[i-39] ^ S[i-58], where negative indices refer to previous-word history.
  - Implement as a single-cycle 32-bit unrolled XOR network.
  - New state = previous state shifted by 32 with out[31:0] appended (out[31] most recent).
  - With BYPASS=1, out = d, but the LFSR still updates with d so that toggling BYPASS is deterministic.
- Header handling:
  - Toggle=0 (first half): o_hdr<=i_hdr; o_hdr_err pulses one cycle later if i_hdr is 00 or 11. The header is forwarded unmodified.
  - Toggle=1 (second half): o_hdr<=2'b00; no error check.
  - The toggle inverts on every accepted word. Two accepted words always form one block; pauses and idles between halves are permitted.
- Simultaneous i_data_valid=1 and i_gearbox_pause=1: pause wins; the word is not accepted and the encoder must re-present it.
- o_hdr_err is low on every cycle except the single pulse cycle.
- No combinational path from i_data/i_hdr to any output other than o_encoder_pause.

Test Plan:
1. Reset, then LFSR_SEED=all-ones, BYPASS=0, two accepted words i_data=0x00000000, first i_hdr=2'b10 -> cycle+1: o_data=0x00000000, o_hdr=10; cycle+2: o_data=0x03FFFF80, o_hdr=00.
2. LFSR_SEED=0, stream of 64 zero words -> every o_data=0x00000000, o_data_valid=1 each cycle after the first, o_hdr alternates 01/00 per input header.
3. BYPASS=1, words 0xDEADBEEF, 0x12345678 -> o_data identical one cycle later; o_hdr_err=0.
4. Random 1000-block stream with i_gearbox_pause asserted every 32nd cycle -> o_data matches a bit-serial G(x) reference model; outputs held unchanged during pause cycles; o_encoder_pause mirrors pause with the same cycle.
5. First-half word with i_hdr=2'b11 -> o_hdr_err=1 for exactly one cycle, one cycle after acceptance; a second-half word with any i_hdr -> no pulse.
6. Assert i_reset after the first half of a block -> all outputs 0 next cycle, LFSR=seed; the next accepted word is treated as a first half (header captured, scrambling restarts from the seed).

Source files
------------

// File: rtl/tx_scrambler_64b66b_if.sv
// Encoder/gearbox-side bus of the 64b/66b TX scrambler.
// The master drives the payload and pause and consumes the scrambled output.
// The slave is the scrambler itself.
interface tx_scrambler_64b66b_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_data_valid;
  logic [1:0]            i_hdr;
  logic                  i_gearbox_pause;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic [1:0]            o_hdr;
  logic                  o_encoder_pause;
  logic                  o_hdr_err;

  modport master (
    output i_data, i_data_valid, i_hdr, i_gearbox_pause,
    input  o_data, o_data_valid, o_hdr, o_encoder_pause, o_hdr_err
  );

  modport slave (
    input  i_data, i_data_valid, i_hdr, i_gearbox_pause,
    output o_data, o_data_valid, o_hdr, o_encoder_pause, o_hdr_err
  );
endinterface

// File: rtl/tx_scrambler_64b66b.sv
// 10GBASE-R TX self-synchronizing scrambler, G(x) = 1 + x^39 + x^58, 32-bit half-blocks.
// Latency: 1 cycle from an accepted word to o_data/o_hdr/o_data_valid.
// Backpressure: gearbox pause is passed straight to the encoder; during pause all state and outputs hold.
module tx_scrambler_64b66b #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [57:0] LFSR_SEED  = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  tx_scrambler_64b66b_if.slave    bus
);

  // Which half of the 66-bit block the next accepted word belongs to.
  typedef enum logic {
    HALF_FIRST  = 1'b0,
    HALF_SECOND = 1'b1
  } half_e;

  // History of scrambled bits: lfsr_q[k-1] is the bit transmitted k bits ago.
  logic [57:0]           lfsr_q, lfsr_d;
  half_e                 half_q, half_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            hdr_q, hdr_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] scr_w;
  logic [DATA_WIDTH-1:0] out_w;
  logic                  accept_w;

  assign accept_w = bus.i_data_valid & ~bus.i_gearbox_pause;

  // Unrolled scrambler: with 32-bit words both taps (ages 39..8 and 58..27) always
  // fall in the previous-word history, so no intra-word chaining is needed.
  always_comb begin
    scr_w = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scr_w[i] = bus.i_data[i] ^ lfsr_q[38-i] ^ lfsr_q[57-i];
    end
    out_w = BYPASS ? bus.i_data : scr_w;
  end

  // Next-state: pause freezes everything, accept advances, idle only drops valid.
  always_comb begin
    lfsr_d = lfsr_q;
    half_d = half_q;
    data_d = data_q;
    hdr_d  = hdr_q;
    vld_d  = vld_q;
    err_d  = 1'b0;
    if (bus.i_gearbox_pause) begin
      // hold: the gearbox counter must not see any change
    end else if (accept_w) begin
      // bit 0 goes out first, so bit 31 ends up as the most recent history bit
      lfsr_d[57:32] = lfsr_q[25:0];
      for (int i = 0; i < DATA_WIDTH; i++) begin
        lfsr_d[31-i] = out_w[i];
      end
      data_d = out_w;
      vld_d  = 1'b1;
      if (half_q == HALF_FIRST) begin
        hdr_d  = bus.i_hdr;
        err_d  = (bus.i_hdr == 2'b00) || (bus.i_hdr == 2'b11);
        half_d = HALF_SECOND;
      end else begin
        hdr_d  = 2'b00;
        half_d = HALF_FIRST;
      end
    end else begin
      vld_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lfsr_q <= LFSR_SEED;
      half_q <= HALF_FIRST;
      data_q <= '0;
      hdr_q  <= 2'b00;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      half_q <= half_d;
      data_q <= data_d;
      hdr_q  <= hdr_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_data          = data_q;
  assign bus.o_hdr           = hdr_q;
  assign bus.o_data_valid    = vld_q;
  assign bus.o_hdr_err       = err_q;
  assign bus.o_encoder_pause = bus.i_gearbox_pause;

endmodule

// File: tb/tb_tx_scrambler_64b66b.sv
// Directed and reference-model bench for tx_scrambler_64b66b.
// Three instances: default seed, zero seed, and bypass.
// All inputs are driven at posedge+1 and outputs sampled at posedge+1.
module tb_tx_scrambler_64b66b;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tx_scrambler_64b66b_if #(.DATA_WIDTH(32)) if_a ();
  tx_scrambler_64b66b_if #(.DATA_WIDTH(32)) if_z ();
  tx_scrambler_64b66b_if #(.DATA_WIDTH(32)) if_b ();

  tx_scrambler_64b66b #(.DATA_WIDTH(32), .LFSR_SEED(58'h3FF_FFFF_FFFF_FFFF), .BYPASS(1'b0))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a));
  tx_scrambler_64b66b #(.DATA_WIDTH(32), .LFSR_SEED(58'h0), .BYPASS(1'b0))
    dut_z (.i_clk(clk), .i_reset(rst), .bus(if_z));
  tx_scrambler_64b66b #(.DATA_WIDTH(32), .LFSR_SEED(58'h3FF_FFFF_FFFF_FFFF), .BYPASS(1'b1))
    dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b));

  task automatic drive(input logic v, input logic p, input logic [31:0] d, input logic [1:0] h);
    if_a.i_data_valid = v; if_a.i_gearbox_pause = p; if_a.i_data = d; if_a.i_hdr = h;
    if_z.i_data_valid = v; if_z.i_gearbox_pause = p; if_z.i_data = d; if_z.i_hdr = h;
    if_b.i_data_valid = v; if_b.i_gearbox_pause = p; if_b.i_data = d; if_b.i_hdr = h;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 2'b10);
    tick();
    do_reset();
    checks++; if (if_a.o_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", if_a.o_data, 32'h0); end
    checks++; if (if_a.o_data_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", if_a.o_data_valid); end
    checks++; if (if_a.o_hdr !== 2'b00) begin failures++; $display("FAIL reset_hdr got=%b exp=00", if_a.o_hdr); end
    checks++; if (if_a.o_hdr_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", if_a.o_hdr_err); end
    checks++; if (if_b.o_data !== 32'h0) begin failures++; $display("FAIL reset_data_b got=%h exp=%h", if_b.o_data, 32'h0); end
    drive(1'b0, 1'b1, 32'h0, 2'b00);
    #1;
    checks++; if (if_a.o_encoder_pause !== 1'b1) begin failures++; $display("FAIL pause_mirror_hi got=%b exp=1", if_a.o_encoder_pause); end
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    #1;
    checks++; if (if_a.o_encoder_pause !== 1'b0) begin failures++; $display("FAIL pause_mirror_lo got=%b exp=0", if_a.o_encoder_pause); end
    tick();
  endtask

  task automatic test_first_vectors;
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 2'b10);
    tick();
    checks++; if (if_a.o_data !== 32'h0) begin failures++; $display("FAIL v1_w0_data got=%h exp=%h", if_a.o_data, 32'h0); end
    checks++; if (if_a.o_hdr !== 2'b10) begin failures++; $display("FAIL v1_w0_hdr got=%b exp=10", if_a.o_hdr); end
    checks++; if (if_a.o_data_valid !== 1'b1) begin failures++; $display("FAIL v1_w0_vld got=%b exp=1", if_a.o_data_valid); end
    drive(1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    checks++; if (if_a.o_data !== 32'h03FF_FF80) begin failures++; $display("FAIL v1_w1_data got=%h exp=%h", if_a.o_data, 32'h03FF_FF80); end
    checks++; if (if_a.o_hdr !== 2'b00) begin failures++; $display("FAIL v1_w1_hdr got=%b exp=00", if_a.o_hdr); end
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    tick();
    checks++; if (if_a.o_data_valid !== 1'b0) begin failures++; $display("FAIL idle_vld got=%b exp=0", if_a.o_data_valid); end
    checks++; if (if_a.o_data !== 32'h03FF_FF80) begin failures++; $display("FAIL idle_hold got=%h exp=%h", if_a.o_data, 32'h03FF_FF80); end
  endtask

  task automatic test_pause_priority;
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 2'b10);
    tick();
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b01);
    tick();
    checks++; if (if_a.o_data !== 32'h0) begin failures++; $display("FAIL pause_hold_data got=%h exp=%h", if_a.o_data, 32'h0); end
    checks++; if (if_a.o_hdr !== 2'b10) begin failures++; $display("FAIL pause_hold_hdr got=%b exp=10", if_a.o_hdr); end
    checks++; if (if_a.o_data_valid !== 1'b1) begin failures++; $display("FAIL pause_hold_vld got=%b exp=1", if_a.o_data_valid); end
    drive(1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    checks++; if (if_a.o_data !== 32'h03FF_FF80) begin failures++; $display("FAIL after_pause_data got=%h exp=%h", if_a.o_data, 32'h03FF_FF80); end
    checks++; if (if_a.o_hdr !== 2'b00) begin failures++; $display("FAIL after_pause_hdr got=%b exp=00", if_a.o_hdr); end
  endtask

  task automatic test_zero_stream;
    logic [1:0] eh;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, 1'b0, 32'h0, 2'b01);
      tick();
      eh = (k % 2 == 0) ? 2'b01 : 2'b00;
      checks++; if (if_z.o_data !== 32'h0) begin failures++; $display("FAIL zero_data k=%0d got=%h exp=%h", k, if_z.o_data, 32'h0); end
      checks++; if (if_z.o_data_valid !== 1'b1) begin failures++; $display("FAIL zero_vld k=%0d got=%b exp=1", k, if_z.o_data_valid); end
      checks++; if (if_z.o_hdr !== eh) begin failures++; $display("FAIL zero_hdr k=%0d got=%b exp=%b", k, if_z.o_hdr, eh); end
    end
  endtask

  task automatic test_bypass;
    do_reset();
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 2'b10);
    tick();
    checks++; if (if_b.o_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL byp_w0 got=%h exp=%h", if_b.o_data, 32'hDEAD_BEEF); end
    checks++; if (if_b.o_hdr_err !== 1'b0) begin failures++; $display("FAIL byp_err0 got=%b exp=0", if_b.o_hdr_err); end
    drive(1'b1, 1'b0, 32'h1234_5678, 2'b00);
    tick();
    checks++; if (if_b.o_data !== 32'h1234_5678) begin failures++; $display("FAIL byp_w1 got=%h exp=%h", if_b.o_data, 32'h1234_5678); end
    checks++; if (if_b.o_hdr_err !== 1'b0) begin failures++; $display("FAIL byp_err1 got=%b exp=0", if_b.o_hdr_err); end
  endtask

  task automatic test_hdr_err;
    do_reset();
    drive(1'b1, 1'b0, 32'hA5A5_A5A5, 2'b11);
    #1;
    checks++; if (if_a.o_hdr_err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", if_a.o_hdr_err); end
    tick();
    checks++; if (if_a.o_hdr_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", if_a.o_hdr_err); end
    checks++; if (if_a.o_hdr !== 2'b11) begin failures++; $display("FAIL err_hdr_fwd got=%b exp=11", if_a.o_hdr); end
    drive(1'b1, 1'b0, 32'h5A5A_5A5A, 2'b11);
    tick();
    checks++; if (if_a.o_hdr_err !== 1'b0) begin failures++; $display("FAIL err_second_half got=%b exp=0", if_a.o_hdr_err); end
    drive(1'b1, 1'b0, 32'h0, 2'b00);
    tick();
    checks++; if (if_a.o_hdr_err !== 1'b1) begin failures++; $display("FAIL err_00 got=%b exp=1", if_a.o_hdr_err); end
    drive(1'b0, 1'b1, 32'h0, 2'b00);
    tick();
    checks++; if (if_a.o_hdr_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", if_a.o_hdr_err); end
  endtask

  task automatic test_reset_mid_block;
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 2'b10);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 2'b01);
    tick();
    rst = 1'b0;
    checks++; if (if_a.o_data !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=%h", if_a.o_data, 32'h0); end
    checks++; if (if_a.o_data_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", if_a.o_data_valid); end
    drive(1'b1, 1'b0, 32'h0, 2'b01);
    tick();
    checks++; if (if_a.o_hdr !== 2'b01) begin failures++; $display("FAIL mid_rst_hdr got=%b exp=01", if_a.o_hdr); end
    checks++; if (if_a.o_data !== 32'h0) begin failures++; $display("FAIL mid_rst_w0 got=%h exp=%h", if_a.o_data, 32'h0); end
    drive(1'b1, 1'b0, 32'h0, 2'b10);
    tick();
    checks++; if (if_a.o_data !== 32'h03FF_FF80) begin failures++; $display("FAIL mid_rst_w1 got=%h exp=%h", if_a.o_data, 32'h03FF_FF80); end
    checks++; if (if_a.o_hdr !== 2'b00) begin failures++; $display("FAIL mid_rst_hdr1 got=%b exp=00", if_a.o_hdr); end
  endtask

  task automatic test_random_stream;
    logic [57:0] ms;
    logic        mhalf;
    logic [31:0] ed;
    logic [1:0]  eh;
    logic        ev, ee, o, p, v;
    logic [31:0] d;
    logic [1:0]  h;
    int          words;
    do_reset();
    ms = '1; mhalf = 1'b0; ed = '0; eh = 2'b00; ev = 1'b0; ee = 1'b0; words = 0;
    for (int cyc = 0; cyc < 4000 && words < 2000; cyc++) begin
      p = (cyc % 32 == 31);
      v = ($urandom_range(0, 7) != 0);
      d = $urandom;
      h = 2'($urandom_range(0, 3));
      drive(v, p, d, h);
      #1;
      checks++; if (if_a.o_encoder_pause !== p) begin failures++; $display("FAIL rnd_pause cyc=%0d got=%b exp=%b", cyc, if_a.o_encoder_pause, p); end
      tick();
      ee = 1'b0;
      if (!p && v) begin
        for (int i = 0; i < 32; i++) begin
          o = d[i] ^ ms[38] ^ ms[57];
          ms = {ms[56:0], o};
          ed[i] = o;
        end
        eh = mhalf ? 2'b00 : h;
        ee = !mhalf && (h == 2'b00 || h == 2'b11);
        mhalf = ~mhalf;
        ev = 1'b1;
        words++;
      end else if (!p) begin
        ev = 1'b0;
      end
      checks++; if (if_a.o_data !== ed) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, if_a.o_data, ed); end
      checks++; if (if_a.o_hdr !== eh) begin failures++; $display("FAIL rnd_hdr cyc=%0d got=%b exp=%b", cyc, if_a.o_hdr, eh); end
      checks++; if (if_a.o_data_valid !== ev) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, if_a.o_data_valid, ev); end
      checks++; if (if_a.o_hdr_err !== ee) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, if_a.o_hdr_err, ee); end
    end
    checks++; if (words != 2000) begin failures++; $display("FAIL rnd_word_budget got=%0d exp=2000", words); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    #1;
    test_reset();
    test_first_vectors();
    test_pause_priority();
    test_zero_stream();
    test_bypass();
    test_hdr_err();
    test_reset_mid_block();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
